// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch state, instruction field positions and constants
package fetch_unit_pkg;
  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} fetch_state_t;
  localparam int INSTR_W = 32;
  localparam int PC_INC = 4;
  localparam int IMM26_MSB = 25;
  localparam int IMM26_LSB = 0;
  localparam int IMM19_MSB = 23;
  localparam int IMM19_LSB = 5;
endpackage

// File: rtl/fetch_unit_branch_target.sv
// branch_target: sign-extended, word-scaled branch offset added to the branch PC
module branch_target
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH = 64
) (
  input  logic [INSTR_W-1:0]  instr,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                uncond,
  output logic [PC_WIDTH-1:0] target
);
  logic [PC_WIDTH-1:0] imm26;
  logic [PC_WIDTH-1:0] imm19;
  always_comb begin
    imm26 = PC_WIDTH'($signed(instr[IMM26_MSB:IMM26_LSB]));
    imm19 = PC_WIDTH'($signed(instr[IMM19_MSB:IMM19_LSB]));
    target = pc + ((uncond ? imm26 : imm19) << 2);
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with branch redirect and valid/ready output register
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic [INSTR_W-1:0]  instruction,
  output logic [PC_WIDTH-1:0] instrPC,
  output logic                instrValid,
  input  logic                decodeReady,
  input  logic                branch,
  input  logic                unconditionalBranch,
  input  logic                aluZero,
  input  logic [INSTR_W-1:0]  branchInstruction,
  input  logic [PC_WIDTH-1:0] branchPC
);
  fetch_state_t state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_n;
  logic [PC_WIDTH-1:0] target;
  logic taken;
  logic consume;
  logic capture;
  logic req_free;
  logic valid_n;
  logic issue;
  branch_target #(.PC_WIDTH(PC_WIDTH)) u_target (
    .instr (branchInstruction),
    .pc    (branchPC),
    .uncond(unconditionalBranch),
    .target(target)
  );
  always_comb begin
    taken = unconditionalBranch || (branch && aluZero);
    consume = instrValid && decodeReady;
    capture = state == WAIT && imem_ack && !taken;
    req_free = state == FETCH || imem_ack;
    valid_n = taken ? 1'b0 : capture ? 1'b1 : consume ? 1'b0 : instrValid;
    issue = req_free && !valid_n;
    pc_n = taken ? target : capture ? pc + PC_WIDTH'(PC_INC) : pc;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      instrValid <= 1'b0;
      instruction <= '0;
      instrPC <= '0;
    end else begin
      pc <= pc_n;
      instrValid <= valid_n;
      if (capture) begin
        instruction <= imem_rdata;
        instrPC <= pc;
      end
      if (issue) begin
        imem_req <= 1'b1;
        imem_addr <= pc_n;
        state <= WAIT;
      end else if (req_free) begin
        imem_req <= 1'b0;
        state <= FETCH;
      end else if (taken) begin
        state <= DRAIN;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic checked by a program-order scoreboard
module tb_fetch_unit;
  localparam logic [63:0] RPC = 64'hFFFF_FFFF_FFFF_FFFC;
  typedef struct packed {logic [63:0] pc; logic [31:0] ins;} ent_t;
  typedef struct packed {logic rst; logic inv; logic val; logic req; logic noreq; logic [63:0] addr;} expf_t;
  logic clock = 0;
  logic reset = 1;
  logic imem_req;
  logic [63:0] imem_addr;
  logic imem_ack = 0;
  logic [31:0] imem_rdata = 0;
  logic [31:0] instruction;
  logic [63:0] instrPC;
  logic instrValid;
  logic decodeReady = 0;
  logic branch = 0;
  logic unconditionalBranch = 0;
  logic aluZero = 0;
  logic [31:0] branchInstruction = 0;
  logic [63:0] branchPC = 0;
  ent_t exp_q[$];
  expf_t cur_e = '0;
  expf_t nxt_e = '0;
  int checks = 0;
  int failures = 0;
  always #5 clock = ~clock;
  fetch_unit #(.PC_WIDTH(64), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
    .instrPC(instrPC), .instrValid(instrValid), .decodeReady(decodeReady),
    .branch(branch), .unconditionalBranch(unconditionalBranch), .aluZero(aluZero),
    .branchInstruction(branchInstruction), .branchPC(branchPC)
  );
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0F0F;
  endfunction
  function automatic logic [63:0] target_of(input logic ub, input logic [31:0] ins, input logic [63:0] pc);
    logic signed [25:0] i26;
    logic signed [18:0] i19;
    longint off;
    i26 = ins[25:0];
    i19 = ins[23:5];
    off = ub ? longint'(i26) : longint'(i19);
    return pc + 64'(off * 4);
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  always @(negedge clock) begin
    if (cur_e.rst) begin
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, RPC);
      chk("rst_valid", instrValid, 0);
      chk("rst_instr", instruction, 0);
      chk("rst_pc", instrPC, 0);
    end
    if (cur_e.inv) chk("valid_cleared", instrValid, 0);
    if (cur_e.val) chk("valid_set", instrValid, 1);
    if (cur_e.req) begin
      chk("req_high", imem_req, 1);
      chk("req_addr", imem_addr, cur_e.addr);
    end
    if (cur_e.noreq) chk("backpressure_noreq", imem_req, 0);
    if (instrValid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=pc %h required=no instruction", instrPC);
      end else begin
        chk("instr_pc", instrPC, exp_q[0].pc);
        chk("instr_word", instruction, exp_q[0].ins);
        if (decodeReady && !reset && !(unconditionalBranch || (branch && aluZero)))
          void'(exp_q.pop_front());
      end
    end
  end
  initial begin
    bit pend = 0;
    int cnt = 0;
    bit draining = 0;
    bit did_rst = 0;
    int rst_at = 1 << 30;
    int bidx = 0;
    bit stray, taken, cons, outst;
    bit p_rst = 1, p_taken = 0, p_cons = 0, p_ack = 0, p_out = 0;
    logic [63:0] model_pc = RPC, drain_tgt = 0, tgt = 0, p_tgt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock);
      #1;
      cur_e = nxt_e;
      nxt_e = '0;
      if (p_rst) begin
        exp_q.delete();
        model_pc = RPC;
        exp_q.push_back('{model_pc, mem_word(model_pc)});
        draining = 0;
      end else if (p_taken) begin
        exp_q.delete();
        model_pc = p_tgt;
        exp_q.push_back('{model_pc, mem_word(model_pc)});
        draining = p_out;
      end else begin
        if (p_cons) begin
          model_pc = model_pc + 64'd4;
          exp_q.push_back('{model_pc, mem_word(model_pc)});
        end
        if (draining && p_ack) draining = 0;
      end
      if (c >= 1500 && !did_rst && imem_req && pend && cnt > 0) begin
        did_rst = 1;
        rst_at = c;
      end
      reset = (c < 3) || (c >= rst_at && c < rst_at + 3);
      stray = (c == rst_at + 3);
      if (reset) begin
        imem_ack = (c == rst_at + 1);
        pend = 0;
      end else if (stray) begin
        imem_ack = 1;
      end else if (imem_req) begin
        if (!pend) begin
          pend = 1;
          cnt = $urandom_range(0, 3);
        end
        imem_ack = (cnt == 0);
        if (imem_ack) pend = 0;
        else cnt--;
      end else begin
        imem_ack = 0;
        pend = 0;
      end
      imem_rdata = (imem_ack && imem_req) ? mem_word(imem_addr) : $urandom;
      decodeReady = $urandom_range(0, 3) != 0;
      branch = 0;
      unconditionalBranch = 0;
      aluZero = $urandom_range(0, 1);
      branchInstruction = $urandom;
      branchPC = {$urandom, $urandom};
      if (!reset && $urandom_range(0, 9) == 0) begin
        case (bidx)
          0: begin unconditionalBranch = 1; branchInstruction = 32'h17FF_FFFF; branchPC = 64'h200; end
          1: begin branch = 1; aluZero = 1; branchInstruction = 32'hB400_0080; branchPC = 64'h40; end
          2: begin branch = 1; aluZero = 0; branchInstruction = 32'hB400_0080; branchPC = 64'h40; end
          3: begin branch = 1; unconditionalBranch = 1; aluZero = 1; end
          default: begin
            branch = $urandom_range(0, 1);
            unconditionalBranch = $urandom_range(0, 1);
          end
        endcase
        bidx++;
      end
      taken = unconditionalBranch || (branch && aluZero);
      tgt = target_of(unconditionalBranch, branchInstruction, branchPC);
      if (taken) drain_tgt = tgt;
      cons = instrValid && decodeReady && !taken && !reset;
      outst = imem_req && !imem_ack;
      if (reset) begin
        nxt_e.rst = 1;
      end else if (taken) begin
        nxt_e.inv = 1;
        nxt_e.req = 1;
        nxt_e.addr = outst ? imem_addr : tgt;
      end else if (draining && imem_req && imem_ack) begin
        nxt_e.inv = 1;
        nxt_e.req = 1;
        nxt_e.addr = drain_tgt;
      end else if (outst) begin
        nxt_e.req = 1;
        nxt_e.addr = imem_addr;
      end else if (imem_req && imem_ack) begin
        nxt_e.val = 1;
      end else if (!instrValid || cons) begin
        nxt_e.inv = 1;
        nxt_e.req = 1;
        nxt_e.addr = cons ? model_pc + 64'd4 : model_pc;
      end else begin
        nxt_e.val = 1;
        nxt_e.noreq = 1;
      end
      p_rst = reset;
      p_taken = taken && !reset;
      p_tgt = tgt;
      p_cons = cons;
      p_ack = imem_ack && imem_req;
      p_out = outst;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
